// File: rtl/disp_sel_ctrl.sv
// Display mux select controller for the alarm clock: chooses alarm vs current
// time, drives blink blanking and the alarm-edit flag, with inactivity timeout.
module disp_sel_ctrl #(
  parameter int unsigned TIMEOUT_S = 5,
  parameter int unsigned CNT_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       show_req,
  input  logic       edit_req,
  input  logic       adj,
  input  logic       ring,
  output logic       sel,
  output logic       blank,
  output logic       edit,
  output logic [1:0] state
);

  // state | meaning
  // TIME  | current time shown, idle
  // VIEW  | alarm time shown, times out after TIMEOUT_S ticks
  // EDIT  | alarm time shown blinking, user editing, times out
  // RING  | alarm ringing, current time shown blinking
  typedef enum logic [1:0] {
    ST_TIME = 2'd0,
    ST_VIEW = 2'd1,
    ST_EDIT = 2'd2,
    ST_RING = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_S - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blank_q, blank_d;
  logic             sel_q, sel_d;
  logic             edit_q, edit_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    unique case (state_q)
      ST_TIME: begin
        if (ring)          state_d = ST_RING;
        else if (edit_req) state_d = ST_EDIT;
        else if (show_req) state_d = ST_VIEW;
      end
      ST_VIEW: begin
        if (ring)          state_d = ST_RING;
        else if (edit_req) state_d = ST_EDIT;
        else if (show_req) state_d = ST_TIME;
        else if (tick) begin
          if (cnt_q == CNT_MAX) state_d = ST_TIME;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_EDIT: begin
        if (ring)          state_d = ST_RING;
        else if (edit_req) state_d = ST_TIME;
        else if (adj) begin
          // adjusting restarts the timeout but the blink keeps its rhythm
          cnt_d = '0;
          if (tick) blank_d = ~blank_q;
        end else if (tick) begin
          blank_d = ~blank_q;
          if (cnt_q == CNT_MAX) state_d = ST_TIME;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_RING: begin
        if (!ring)     state_d = ST_TIME;
        else if (tick) blank_d = ~blank_q;
      end
      default: state_d = ST_TIME;
    endcase

    // any change of state is an entry: restart timeout and blink phase
    if (state_d != state_q) begin
      cnt_d   = '0;
      blank_d = 1'b0;
    end

    sel_d  = (state_d == ST_VIEW) || (state_d == ST_EDIT);
    edit_d = (state_d == ST_EDIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_TIME;
      cnt_q   <= '0;
      blank_q <= 1'b0;
      sel_q   <= 1'b0;
      edit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      sel_q   <= sel_d;
      edit_q  <= edit_d;
    end
  end

  assign sel   = sel_q;
  assign blank = blank_q;
  assign edit  = edit_q;
  assign state = state_q;

endmodule

// File: tb/tb_disp_sel_ctrl.sv
// Scoreboarded directed bench for disp_sel_ctrl: each step queues the
// hand-derived output {state,sel,blank,edit} expected after the next edge.
module tb_disp_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, show_req, edit_req, adj, ring;
  logic       sel, blank, edit;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];

  localparam logic [5:0] NO = 6'b000000;
  localparam logic [5:0] TK = 6'b000001;
  localparam logic [5:0] AD = 6'b000010;
  localparam logic [5:0] SH = 6'b000100;
  localparam logic [5:0] ED = 6'b001000;
  localparam logic [5:0] RG = 6'b010000;
  localparam logic [5:0] RS = 6'b100000;

  // expected {state, sel, blank, edit}
  localparam logic [4:0] O_TIME  = 5'b00_0_0_0;
  localparam logic [4:0] O_VIEW  = 5'b01_1_0_0;
  localparam logic [4:0] O_EDIT0 = 5'b10_1_0_1;
  localparam logic [4:0] O_EDIT1 = 5'b10_1_1_1;
  localparam logic [4:0] O_RING0 = 5'b11_0_0_0;
  localparam logic [4:0] O_RING1 = 5'b11_0_1_0;

  disp_sel_ctrl #(.TIMEOUT_S(5), .CNT_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .show_req (show_req),
    .edit_req (edit_req),
    .adj      (adj),
    .ring     (ring),
    .sel      (sel),
    .blank    (blank),
    .edit     (edit),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got state/sel/blank/edit=%b required %b", tag, got, want);
    end
  endtask

  task automatic drive(input logic [5:0] in);
    {rst, ring, edit_req, show_req, adj, tick} = in;
  endtask

  task automatic step(input string tag, input logic [5:0] in, input logic [4:0] want);
    logic [4:0] e;
    @(negedge clk);
    drive(in);
    exp_q.push_back(want);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got %b", tag, {state, sel, blank, edit});
    end else begin
      e = exp_q.pop_front();
      chk(tag, {state, sel, blank, edit}, e);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(NO);
    // random wander, then reset must win from wherever it landed
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive(6'($urandom) & 6'b011111);
    end
    step("rst_1", RS | RG | ED | TK, O_TIME);
    step("rst_2", RS, O_TIME);

    step("time_tick", TK, O_TIME);
    step("time_adj", AD, O_TIME);

    // view timeout after 5 ticks
    step("view_enter", SH, O_VIEW);
    step("view_idle", NO, O_VIEW);
    for (int i = 1; i <= 4; i++) step($sformatf("view_tick%0d", i), TK, O_VIEW);
    step("view_tick5", TK, O_TIME);

    step("view_again", SH, O_VIEW);
    step("view_toggle_off", SH, O_TIME);

    // edit: blink per tick, adj restarts the timeout
    step("edit_enter", ED, O_EDIT0);
    step("edit_show_ign", SH, O_EDIT0);
    for (int i = 1; i <= 4; i++)
      step($sformatf("edit_a_tick%0d", i), TK, (i % 2 == 1) ? O_EDIT1 : O_EDIT0);
    step("edit_adj", AD, O_EDIT0);
    for (int i = 1; i <= 4; i++)
      step($sformatf("edit_b_tick%0d", i), TK, (i % 2 == 1) ? O_EDIT1 : O_EDIT0);
    step("edit_b_tick5", TK, O_TIME);

    // adj coincident with the would-be timeout tick: toggle, no exit
    step("edit2_enter", ED, O_EDIT0);
    for (int i = 1; i <= 4; i++)
      step($sformatf("edit_c_tick%0d", i), TK, (i % 2 == 1) ? O_EDIT1 : O_EDIT0);
    step("edit_adj_tick5", AD | TK, O_EDIT1);
    step("edit_hold", NO, O_EDIT1);
    step("edit_leave", ED, O_TIME);

    // ring beats edit_req from view
    step("ring_view", SH, O_VIEW);
    step("ring_enter", RG | ED, O_RING0);
    step("ring_tick1", RG | TK, O_RING1);
    step("ring_tick2", RG | TK, O_RING0);
    step("ring_tick3", RG | TK, O_RING1);
    step("ring_ignore", RG | SH | ED | AD, O_RING1);
    step("ring_drop", NO, O_TIME);

    // simultaneous show/edit: edit wins
    step("both_req", SH | ED, O_EDIT0);
    step("both_exit", ED, O_TIME);

    // reset mid-edit with blank high
    step("rst_edit", ED, O_EDIT0);
    step("rst_edit_tick", TK, O_EDIT1);
    step("rst_mid_edit", RS, O_TIME);
    step("rst_after_tick", TK, O_TIME);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
